// File: rtl/avr_cpu_fetch.sv
// Instruction fetch/sequencer for the AVR core: owns the PC and the program-memory
// read port, and feeds opcode/cycle to the decoder while acting on its control outputs.
module avr_cpu_fetch #(
  parameter int PC_WIDTH     = 11,
  parameter int RESET_VECTOR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] prog_addr,
  input  logic [15:0]         prog_data,
  output logic [15:0]         opcode,
  output logic                cycle,
  output logic [PC_WIDTH-1:0] pc,
  input  logic                hold,
  input  logic [15:0]         pc_update,
  input  logic                stack_write,
  input  logic                stack_read,
  input  logic                cond_hold,
  input  logic                cond_true,
  input  logic [15:0]         ret_addr_in,
  output logic [15:0]         call_ret_addr,
  input  logic                lpm_access,
  input  logic [15:0]         lpm_addr,
  output logic [7:0]          lpm_data
);

  typedef enum logic [1:0] {START, EXEC, SECOND} state_t;
  typedef enum logic [1:0] {PLAIN, JUMP, RET} kind_t;

  localparam logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_VECTOR);

  state_t              state_q, state_d;
  kind_t               kind_q, kind_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         opcode_q, opcode_d;
  logic                squash_q, squash_d;
  logic                lpm_sel_q, lpm_sel_d;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] jump_target;
  logic                offset_nz;
  logic                unused_inputs;

  // The stack itself captures call_ret_addr; stack_write is informational here.
  assign unused_inputs = ^{stack_write, ret_addr_in[15:PC_WIDTH], lpm_addr[15:PC_WIDTH+1]};

  assign pc_inc        = pc_q + PC_WIDTH'(1);
  assign jump_target   = pc_inc + pc_update[PC_WIDTH-1:0];
  assign offset_nz     = |pc_update;
  assign pc            = pc_q;
  assign call_ret_addr = 16'(pc_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= START;
      kind_q    <= PLAIN;
      pc_q      <= RESET_PC;
      opcode_q  <= 16'h0000;
      squash_q  <= 1'b0;
      lpm_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      squash_q  <= squash_d;
      lpm_sel_q <= lpm_sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    squash_d  = squash_q;
    lpm_sel_d = lpm_sel_q;
    prog_addr = pc_q;
    opcode    = 16'h0000;
    cycle     = 1'b0;
    lpm_data  = 8'h00;

    unique case (state_q)
      START: begin
        prog_addr = RESET_PC;
        state_d   = EXEC;
      end

      EXEC: begin
        opcode   = squash_q ? 16'h0000 : prog_data;
        opcode_d = opcode;
        squash_d = 1'b0;
        // hold outranks a skip; re-reading pc keeps the ROM port busy with a harmless fetch
        if (hold) begin
          if (lpm_access) begin
            prog_addr = lpm_addr[PC_WIDTH:1];
            lpm_sel_d = lpm_addr[0];
          end
          state_d = SECOND;
          if (stack_read)     kind_d = RET;
          else if (offset_nz) kind_d = JUMP;
          else                kind_d = PLAIN;
        end else if (cond_hold && cond_true && offset_nz) begin
          state_d = SECOND;
          kind_d  = JUMP;
        end else begin
          prog_addr = pc_inc;
          pc_d      = pc_inc;
          squash_d  = cond_hold && cond_true;
        end
      end

      SECOND: begin
        opcode  = opcode_q;
        cycle   = 1'b1;
        state_d = EXEC;
        unique case (kind_q)
          JUMP: begin
            prog_addr = jump_target;
            pc_d      = jump_target;
          end
          RET: begin
            prog_addr = ret_addr_in[PC_WIDTH-1:0];
            pc_d      = ret_addr_in[PC_WIDTH-1:0];
          end
          default: begin
            prog_addr = pc_inc;
            pc_d      = pc_inc;
            lpm_data  = lpm_sel_q ? prog_data[15:8] : prog_data[7:0];
          end
        endcase
      end

      default: state_d = START;
    endcase
  end

endmodule

// File: tb/tb_avr_cpu_fetch.sv
// Scoreboard bench for avr_cpu_fetch: the stimulus thread plays the decoder and queues
// hand-computed expectations; a monitor thread pops and compares once per cycle.
module tb_avr_cpu_fetch;

  typedef struct {
    string       name;
    logic [10:0] pa;
    logic [15:0] op;
    logic        cyc;
    logic [10:0] pc;
    int          lpm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] prog_addr;
  logic [15:0] prog_data = 16'h0000;
  logic [15:0] opcode;
  logic        cycle;
  logic [10:0] pc;
  logic        hold;
  logic [15:0] pc_update;
  logic        stack_write;
  logic        stack_read;
  logic        cond_hold;
  logic        cond_true;
  logic [15:0] ret_addr_in;
  logic [15:0] call_ret_addr;
  logic        lpm_access;
  logic [15:0] lpm_addr;
  logic [7:0]  lpm_data;

  logic [15:0] mem [0:2047];
  exp_t        exp_q[$];
  int          n_vectors = 0;
  int          n_miscompares = 0;
  event        mon_ev;

  avr_cpu_fetch #(.PC_WIDTH(11), .RESET_VECTOR(0)) dut (
    .clk(clk), .rst_n(rst_n), .prog_addr(prog_addr), .prog_data(prog_data),
    .opcode(opcode), .cycle(cycle), .pc(pc), .hold(hold), .pc_update(pc_update),
    .stack_write(stack_write), .stack_read(stack_read), .cond_hold(cond_hold),
    .cond_true(cond_true), .ret_addr_in(ret_addr_in), .call_ret_addr(call_ret_addr),
    .lpm_access(lpm_access), .lpm_addr(lpm_addr), .lpm_data(lpm_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read program ROM with one cycle of latency
  always @(posedge clk) prog_data <= mem[prog_addr];

  task automatic set_idle();
    hold = 1'b0; pc_update = 16'h0000; stack_write = 1'b0; stack_read = 1'b0;
    cond_hold = 1'b0; cond_true = 1'b0; ret_addr_in = 16'h0000;
    lpm_access = 1'b0; lpm_addr = 16'h0000;
  endtask

  task automatic push_exp(string name, logic [10:0] pa, logic [15:0] op, logic cyc,
                          logic [10:0] epc, int lpm);
    exp_t e;
    e.name = name; e.pa = pa; e.op = op; e.cyc = cyc; e.pc = epc; e.lpm = lpm;
    exp_q.push_back(e);
  endtask

  // Inputs for this cycle are already driven by the caller; hold them until the next edge
  task automatic apply_stimulus(string name, logic [10:0] pa, logic [15:0] op, logic cyc,
                                logic [10:0] epc, int lpm);
    push_exp(name, pa, op, cyc, epc, lpm);
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic check_output(exp_t e);
    logic [15:0] exp_ret;
    exp_ret = {5'b0, e.pc + 11'd1};
    n_vectors++;
    if (prog_addr !== e.pa) begin
      n_miscompares++;
      $display("[TB] FAIL %s.prog_addr got %h expected %h", e.name, prog_addr, e.pa);
    end
    if (opcode !== e.op) begin
      n_miscompares++;
      $display("[TB] FAIL %s.opcode got %h expected %h", e.name, opcode, e.op);
    end
    if (cycle !== e.cyc) begin
      n_miscompares++;
      $display("[TB] FAIL %s.cycle got %b expected %b", e.name, cycle, e.cyc);
    end
    if (pc !== e.pc) begin
      n_miscompares++;
      $display("[TB] FAIL %s.pc got %h expected %h", e.name, pc, e.pc);
    end
    if (call_ret_addr !== exp_ret) begin
      n_miscompares++;
      $display("[TB] FAIL %s.call_ret_addr got %h expected %h", e.name, call_ret_addr, exp_ret);
    end
    if (e.lpm >= 0 && lpm_data !== 8'(e.lpm)) begin
      n_miscompares++;
      $display("[TB] FAIL %s.lpm_data got %h expected %h", e.name, lpm_data, 8'(e.lpm));
    end
  endtask

  // Monitor: one comparison per cycle, plus on-demand checks for the async reset pulse
  initial begin
    forever begin
      @(negedge clk or mon_ev);
      if (exp_q.size() > 0) check_output(exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[0]  = 16'hE0A5;  mem[1]  = 16'h9503;  mem[2]  = 16'hC005;  mem[3] = 16'h9403;
    mem[8]  = 16'h1001;  mem[9]  = 16'h2C01;  mem[10] = 16'hD004;
    mem[11] = 16'h1001;  mem[12] = 16'h95C8;  mem[13] = 16'hF011;
    mem[15] = 16'h9508;  mem[16] = 16'hCFEE;  mem[16'h20] = 16'hBEEF;
    mem[11'h7FF] = 16'h2411;

    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    apply_stimulus("reset", 11'd0, 16'h0000, 1'b0, 11'd0, 0);
    rst_n = 1'b1;
    hold = 1'b1; pc_update = 16'h0003;
    apply_stimulus("start", 11'd0, 16'h0000, 1'b0, 11'd0, 0);
    apply_stimulus("ldi", 11'd1, 16'hE0A5, 1'b0, 11'd0, 0);
    apply_stimulus("inc", 11'd2, 16'h9503, 1'b0, 11'd1, 0);
    hold = 1'b1; pc_update = 16'd5;
    apply_stimulus("rjmp_c0", 11'd2, 16'hC005, 1'b0, 11'd2, 0);
    pc_update = 16'd5;
    apply_stimulus("rjmp_c1", 11'd8, 16'hC005, 1'b1, 11'd2, -1);
    cond_hold = 1'b1; cond_true = 1'b1;
    apply_stimulus("cpse_skip", 11'd9, 16'h1001, 1'b0, 11'd8, 0);
    apply_stimulus("squashed", 11'd10, 16'h0000, 1'b0, 11'd9, 0);
    hold = 1'b1; pc_update = 16'd4; stack_write = 1'b1;
    apply_stimulus("rcall_c0", 11'd10, 16'hD004, 1'b0, 11'd10, 0);
    pc_update = 16'd4;
    apply_stimulus("rcall_c1", 11'd15, 16'hD004, 1'b1, 11'd10, -1);
    hold = 1'b1; stack_read = 1'b1;
    apply_stimulus("ret_c0", 11'd15, 16'h9508, 1'b0, 11'd15, 0);
    ret_addr_in = 16'd11;
    apply_stimulus("ret_c1", 11'd11, 16'h9508, 1'b1, 11'd15, -1);
    cond_hold = 1'b1; cond_true = 1'b0;
    apply_stimulus("cpse_noskip", 11'd12, 16'h1001, 1'b0, 11'd11, 0);
    hold = 1'b1; lpm_access = 1'b1; lpm_addr = 16'h0041;
    apply_stimulus("lpm_c0", 11'h020, 16'h95C8, 1'b0, 11'd12, 0);
    apply_stimulus("lpm_c1", 11'd13, 16'h95C8, 1'b1, 11'd12, 8'hBE);
    cond_hold = 1'b1; cond_true = 1'b1; pc_update = 16'd2;
    apply_stimulus("breq_c0", 11'd13, 16'hF011, 1'b0, 11'd13, 0);
    cond_hold = 1'b1; pc_update = 16'd2;
    apply_stimulus("breq_c1", 11'd16, 16'hF011, 1'b1, 11'd13, -1);
    hold = 1'b1; pc_update = 16'hFFEE;
    apply_stimulus("rjmp_back_c0", 11'd16, 16'hCFEE, 1'b0, 11'd16, 0);
    pc_update = 16'hFFEE;
    apply_stimulus("rjmp_back_c1", 11'h7FF, 16'hCFEE, 1'b1, 11'd16, -1);
    apply_stimulus("wrap", 11'd0, 16'h2411, 1'b0, 11'h7FF, 0);
    apply_stimulus("ldi2", 11'd1, 16'hE0A5, 1'b0, 11'd0, 0);
    apply_stimulus("inc2", 11'd2, 16'h9503, 1'b0, 11'd1, 0);
    hold = 1'b1; pc_update = 16'd5;
    apply_stimulus("rjmp2_c0", 11'd2, 16'hC005, 1'b0, 11'd2, 0);

    // Short reset pulse inside the RJMP second cycle, released before the next edge
    pc_update = 16'd5;
    push_exp("rjmp2_c1", 11'd8, 16'hC005, 1'b1, 11'd2, -1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 push_exp("reset_mid", 11'd0, 16'h0000, 1'b0, 11'd0, 0);
    -> mon_ev;
    #1 rst_n = 1'b1;
    set_idle();
    @(posedge clk);
    #1;
    apply_stimulus("after_reset", 11'd1, 16'hE0A5, 1'b0, 11'd0, 0);
    apply_stimulus("inc3", 11'd2, 16'h9503, 1'b0, 11'd1, 0);
    hold = 1'b1; cond_hold = 1'b1; cond_true = 1'b1;
    apply_stimulus("hold_wins_c0", 11'd2, 16'hC005, 1'b0, 11'd2, 0);
    apply_stimulus("hold_wins_c1", 11'd3, 16'hC005, 1'b1, 11'd2, 8'h05);
    apply_stimulus("no_squash", 11'd4, 16'h9403, 1'b0, 11'd3, 0);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_miscompares++;
      $display("[TB] FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
